// File: rtl/mdl_sata_fistx.sv
// Device-side SATA link-layer transmit model: frames FIS dwords from a
// response FIFO into X_RDY/SOF/data/CRC/EOF/WTRM and reports the host's verdict.
module mdl_sata_fistx #(
   parameter int WTRM_TIMEOUT = 1024,
   parameter bit OPT_HOLD     = 1'b1
) (
   input  logic        i_phy_clk,
   input  logic        i_reset,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [31:0] s_data,
   input  logic        s_last,
   input  logic        i_rx_prim,
   input  logic [31:0] i_rx_data,
   output logic        o_tx_ctrl,
   output logic [31:0] o_tx_data,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);
   localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
   localparam logic [31:0] P_XRDY  = 32'h5757B57C;
   localparam logic [31:0] P_RRDY  = 32'h4A4A957C;
   localparam logic [31:0] P_SOF   = 32'h3737B57C;
   localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
   localparam logic [31:0] P_WTRM  = 32'h5858B57C;
   localparam logic [31:0] P_ROK   = 32'h3535B57C;
   localparam logic [31:0] P_RERR  = 32'h5656B57C;
   localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] P_HOLDA = 32'h9595AA7C;
   localparam logic [31:0] CRC_SEED = 32'h52325032;
   localparam int CW = $clog2(WTRM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_XRDY, S_SOF, S_DATA, S_CRC, S_EOF, S_WTERM, S_DRAIN
   } state_t;

   state_t        state, state_nx;
   logic [31:0]   crc, crc_nx, tx_data_nx;
   logic          tx_ctrl_nx, done_nx, err_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          rx_sync, rx_hold, rx_rrdy, rx_rok, rx_rerr;

   // CRC-32, poly 0x04C11DB7, data consumed MSB first, no reflection/final XOR
   function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 31; i >= 0; i--)
         r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
      return r;
   endfunction

   assign rx_sync = i_rx_prim && (i_rx_data == P_SYNC);
   assign rx_hold = i_rx_prim && (i_rx_data == P_HOLD);
   assign rx_rrdy = i_rx_prim && (i_rx_data == P_RRDY);
   assign rx_rok  = i_rx_prim && (i_rx_data == P_ROK);
   assign rx_rerr = i_rx_prim && (i_rx_data == P_RERR);
   assign o_busy  = (state != S_IDLE);

   always_comb begin
      state_nx   = state;
      tx_data_nx = P_SYNC;
      tx_ctrl_nx = 1'b1;
      crc_nx     = crc;
      cnt_nx     = cnt;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      s_ready    = 1'b0;
      case (state)
         S_IDLE: if (s_valid) state_nx = S_XRDY;
         S_XRDY: begin
            tx_data_nx = P_XRDY;
            if (rx_rrdy) state_nx = S_SOF;
         end
         S_SOF: begin
            if (rx_sync) begin
               err_nx   = 1'b1;
               state_nx = S_DRAIN;
            end else begin
               tx_data_nx = P_SOF;
               crc_nx     = CRC_SEED;
               state_nx   = S_DATA;
            end
         end
         S_DATA: begin
            // SYNC abort outranks HOLD; the aborted word is left for the drain
            if (rx_sync) begin
               err_nx   = 1'b1;
               state_nx = S_DRAIN;
            end else if (OPT_HOLD && rx_hold) begin
               tx_data_nx = P_HOLDA;
            end else if (s_valid) begin
               s_ready    = 1'b1;
               tx_data_nx = s_data;
               tx_ctrl_nx = 1'b0;
               crc_nx     = crc32_step(crc, s_data);
               if (s_last) state_nx = S_CRC;
            end else begin
               tx_data_nx = P_HOLD;
            end
         end
         S_CRC, S_EOF: begin
            // last dword already taken, so an abort here needs no drain
            if (rx_sync) begin
               err_nx   = 1'b1;
               state_nx = S_IDLE;
            end else if (state == S_CRC) begin
               tx_data_nx = crc;
               tx_ctrl_nx = 1'b0;
               state_nx   = S_EOF;
            end else begin
               tx_data_nx = P_EOF;
               cnt_nx     = '0;
               state_nx   = S_WTERM;
            end
         end
         S_WTERM: begin
            cnt_nx = cnt + 1'b1;
            if (rx_rok) begin
               done_nx  = 1'b1;
               state_nx = S_IDLE;
            end else if (rx_rerr || rx_sync || cnt == CW'(WTRM_TIMEOUT - 1)) begin
               err_nx   = 1'b1;
               state_nx = S_IDLE;
            end else begin
               tx_data_nx = P_WTRM;
            end
         end
         S_DRAIN: begin
            s_ready = s_valid;
            if (s_valid && s_last) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (i_reset) s_ready = 1'b0;
   end

   always_ff @(posedge i_phy_clk) begin
      if (i_reset) begin
         state     <= S_IDLE;
         o_tx_data <= P_SYNC;
         o_tx_ctrl <= 1'b1;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
         crc       <= CRC_SEED;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         o_tx_data <= tx_data_nx;
         o_tx_ctrl <= tx_ctrl_nx;
         o_done    <= done_nx;
         o_err     <= err_nx;
         crc       <= crc_nx;
         cnt       <= cnt_nx;
      end
   end
endmodule

// File: tb/tb_mdl_sata_fistx.sv
// Table-driven bench for mdl_sata_fistx: scripted host/source per frame scenario,
// stream analysis against a CRC model, plus idle, timeout and reset-mid-frame sequences.
module tb_mdl_sata_fistx;
   localparam int TMO = 1024;
   localparam int LIMIT = TMO + 200;
   localparam logic [31:0] P_SYNC  = 32'hB5B5957C;
   localparam logic [31:0] P_XRDY  = 32'h5757B57C;
   localparam logic [31:0] P_RRDY  = 32'h4A4A957C;
   localparam logic [31:0] P_SOF   = 32'h3737B57C;
   localparam logic [31:0] P_EOF   = 32'hD5D5B57C;
   localparam logic [31:0] P_WTRM  = 32'h5858B57C;
   localparam logic [31:0] P_ROK   = 32'h3535B57C;
   localparam logic [31:0] P_RERR  = 32'h5656B57C;
   localparam logic [31:0] P_HOLD  = 32'hD5D5AA7C;
   localparam logic [31:0] P_HOLDA = 32'h9595AA7C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0, s_last = 1'b0, rx_prim = 1'b0;
   logic [31:0] s_data = '0, rx_data = '0;
   logic        s_ready, tx_ctrl, busy, done, err;
   logic [31:0] tx_data;

   mdl_sata_fistx #(.WTRM_TIMEOUT(TMO), .OPT_HOLD(1'b1)) dut (
      .i_phy_clk(clk), .i_reset(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .i_rx_prim(rx_prim), .i_rx_data(rx_data),
      .o_tx_ctrl(tx_ctrl), .o_tx_data(tx_data),
      .o_busy(busy), .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          nw;
      logic [31:0] hdr, seed;
      int          rrdy_dly, gap_at, gap_len, hold_at, hold_len, sync_at;
      logic        rep_prim;
      logic [31:0] rep_data;
      int          rep_dly, exp_done, exp_err, exp_hold, exp_holda;
   } scen_t;

   int total = 0, bad = 0;
   logic [31:0] dw[$];
   logic [31:0] txd[$];
   logic        txc[$];
   int n_done, n_err, err_cyc, eof_cyc, end_cyc, n_wtrm, hold_leak, idx, tail;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_model(input int n);
      logic [31:0] c;
      c = 32'h52325032;
      for (int k = 0; k < n; k++)
         for (int b = 31; b >= 0; b--)
            if (c[31] ^ dw[k][b]) c = (c << 1) ^ 32'h04C11DB7;
            else c = c << 1;
      return c;
   endfunction

   // Drives source and host for one frame; records the transmitted stream.
   task automatic run_frame(input scen_t sc);
      int  cyc, n_xrdy, n_data, gap_left, hold_left;
      bit  hs, sof_seen, sync_left, rep_left, fin;
      dw.delete(); txd.delete(); txc.delete();
      for (int i = 0; i < sc.nw; i++) dw.push_back(i == 0 ? sc.hdr : sc.seed * i);
      n_done = 0; n_err = 0; err_cyc = -1; eof_cyc = -1; end_cyc = -1;
      n_wtrm = 0; hold_leak = 0; idx = 0; tail = 0;
      cyc = 0; n_xrdy = 0; n_data = 0; hs = 0; sof_seen = 0;
      gap_left = sc.gap_len; hold_left = sc.hold_len; sync_left = 1; rep_left = 1;
      while (tail < 3 && cyc < LIMIT) begin
         @(negedge clk);
         if (hs) idx++;
         txd.push_back(tx_data); txc.push_back(tx_ctrl);
         if (done) begin n_done++; end_cyc = cyc; end
         if (err) begin n_err++; err_cyc = cyc; end_cyc = cyc; end
         if (tx_ctrl && tx_data == P_EOF) eof_cyc = cyc;
         if (tx_ctrl && tx_data == P_XRDY) n_xrdy++;
         if (tx_ctrl && tx_data == P_SOF) sof_seen = 1;
         if (tx_ctrl && tx_data == P_WTRM) n_wtrm++;
         if (!tx_ctrl) n_data++;
         rx_prim = 1'b0; rx_data = '0;
         if (!sof_seen) begin
            // R_RDY as a non-primitive dword must be ignored until it is real
            rx_data = P_RRDY;
            rx_prim = (n_xrdy >= sc.rrdy_dly);
         end else if (sc.sync_at >= 0 && n_data == sc.sync_at && sync_left) begin
            rx_prim = 1'b1; rx_data = P_SYNC; sync_left = 0;
         end else if (sc.hold_at >= 0 && n_data == sc.hold_at && hold_left > 0) begin
            rx_prim = 1'b1; rx_data = P_HOLD; hold_left--;
         end else if (n_wtrm > 0 && n_wtrm >= sc.rep_dly && rep_left) begin
            rx_prim = sc.rep_prim; rx_data = sc.rep_data; rep_left = 0;
         end
         s_valid = 1'b0; s_data = '0; s_last = 1'b0;
         if (idx < sc.nw) begin
            if (sc.gap_at >= 0 && idx == sc.gap_at && gap_left > 0) gap_left--;
            else begin
               s_valid = 1'b1; s_data = dw[idx]; s_last = (idx == sc.nw - 1);
            end
         end
         #1;
         hs = s_valid && s_ready;
         if (rx_prim && rx_data == P_HOLD && s_valid && s_ready) hold_leak++;
         fin = (n_done + n_err > 0) && !busy && (idx + int'(hs) == sc.nw);
         if (fin || tail > 0) tail++;
         cyc++;
      end
      s_valid = 1'b0; s_last = 1'b0; rx_prim = 1'b0; rx_data = '0;
   endtask

   task automatic check_frame(input scen_t sc);
      logic [31:0] dq[$];
      int last, nhold, nholda;
      last = -1; nhold = 0; nholda = 0;
      for (int i = 0; i < txd.size(); i++) begin
         if (!txc[i]) begin dq.push_back(txd[i]); last = i; end
         else if (txd[i] == P_HOLD) nhold++;
         else if (txd[i] == P_HOLDA) nholda++;
      end
      chk({sc.name, ".ended"}, tail, 3);
      chk({sc.name, ".done"}, n_done, sc.exp_done);
      chk({sc.name, ".err"}, n_err, sc.exp_err);
      chk({sc.name, ".hold"}, nhold, sc.exp_hold);
      chk({sc.name, ".holda"}, nholda, sc.exp_holda);
      chk({sc.name, ".hold_leak"}, hold_leak, 0);
      chk({sc.name, ".consumed"}, idx, sc.nw);
      chk({sc.name, ".busy_end"}, busy, 0);
      if (end_cyc >= 0 && end_cyc < txd.size())
         chk({sc.name, ".tx_at_end"}, txd[end_cyc], P_SYNC);
      if (sc.sync_at < 0) begin
         chk({sc.name, ".ndata"}, dq.size(), sc.nw + 1);
         for (int i = 0; i < sc.nw && i < dq.size(); i++)
            chk($sformatf("%s.dw%0d", sc.name, i), dq[i], dw[i]);
         if (dq.size() > sc.nw) chk({sc.name, ".crc"}, dq[sc.nw], crc_model(sc.nw));
         if (last >= 0 && last + 2 < txd.size()) begin
            chk({sc.name, ".eof"}, {txc[last + 1], txd[last + 1]}, {1'b1, P_EOF});
            chk({sc.name, ".wtrm"}, {txc[last + 2], txd[last + 2]}, {1'b1, P_WTRM});
         end
      end else begin
         chk({sc.name, ".ndata"}, dq.size(), sc.sync_at);
         for (int i = 0; i < dq.size() && i < sc.nw; i++)
            chk($sformatf("%s.dw%0d", sc.name, i), dq[i], dw[i]);
         if (last >= 0 && last + 1 < txd.size())
            chk({sc.name, ".sync_next"}, {txc[last + 1], txd[last + 1]}, {1'b1, P_SYNC});
         chk({sc.name, ".abort_at"}, end_cyc, last + 1);
      end
   endtask

   initial begin
      scen_t tbl[7];
      scen_t tmo;
      int seen;
      //          name     nw hdr            seed           rrdy gap    hold   sync  rep_prim rep_data dly done err hold holda
      tbl[0] = '{"fis5",  5, 32'h00770027, 32'h0,        3, -1, 0, -1, 0, -1, 1'b1, P_ROK,  4, 1, 0, 0, 0};
      tbl[1] = '{"gap2",  5, 32'h00770027, 32'h0,        3,  2, 2, -1, 0, -1, 1'b1, P_ROK,  4, 1, 0, 2, 0};
      tbl[2] = '{"hold3", 5, 32'h12345678, 32'h9E3779B9, 1, -1, 0,  2, 3, -1, 1'b1, P_ROK,  2, 1, 0, 0, 3};
      tbl[3] = '{"sync2", 5, 32'h00770027, 32'hA5A5A5A5, 3, -1, 0, -1, 0,  2, 1'b1, P_ROK,  1, 0, 1, 0, 0};
      tbl[4] = '{"rerr",  3, 32'hDEADBEEF, 32'h01010101, 2, -1, 0, -1, 0, -1, 1'b1, P_RERR, 1, 0, 1, 0, 0};
      tbl[5] = '{"hsync", 1, 32'hFFFFFFFF, 32'h0,        0, -1, 0, -1, 0, -1, 1'b1, P_SYNC, 2, 0, 1, 0, 0};
      tbl[6] = '{"noprim",2, 32'h80000001, 32'h7,        1, -1, 0, -1, 0, -1, 1'b0, P_ROK,  1, 0, 1, 0, 0};

      // reset state, with a pending source word that must not be taken
      rst = 1'b1; s_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.tx", tx_data, P_SYNC);
      chk("rst.ctrl", tx_ctrl, 1);
      chk("rst.busy", busy, 0);
      chk("rst.done_err", {done, err}, 2'b00);
      chk("rst.s_ready", s_ready, 0);
      s_valid = 1'b0; rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", i), {tx_ctrl, tx_data, busy}, {1'b1, P_SYNC, 1'b0});
      end

      for (int t = 0; t < 7; t++) begin
         run_frame(tbl[t]);
         check_frame(tbl[t]);
      end

      // silent host: error exactly TMO cycles after WAIT_TERM entry (EOF on the wire)
      tmo = '{"tmo", 2, 32'h00000034, 32'h11, 1, -1, 0, -1, 0, -1, 1'b1, P_ROK, 100000, 0, 1, 0, 0};
      run_frame(tmo);
      check_frame(tmo);
      chk("tmo.latency", err_cyc - eof_cyc, TMO);
      chk("tmo.nwtrm", n_wtrm, TMO - 1);

      // reset in mid-frame: frame dropped, no error pulse, no drain
      s_valid = 1'b1; s_data = 32'hCAFE0000; s_last = 1'b0;
      rx_prim = 1'b1; rx_data = P_RRDY;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (!tx_ctrl) seen = 1;
      end
      chk("rstmid.reached_data", seen, 1);
      rx_prim = 1'b0; rx_data = '0;
      rst = 1'b1;
      #1 chk("rstmid.s_ready", s_ready, 0);
      @(negedge clk);
      chk("rstmid.state", {tx_ctrl, tx_data, busy, err, done}, {1'b1, P_SYNC, 3'b000});
      rst = 1'b0; s_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (err || done || busy) seen++;
      end
      chk("rstmid.quiet", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdl_sata_fistx.md
MDL_SATA_FISTX -- requirements
Module: mdl_sata_fistx

Device-side link-layer transmit model: frames FIS dwords from the command model's response FIFO into SATA primitives and CRC.

Interface
- REQ-001 Parameter: WTRM_TIMEOUT, default 1024, meaning: max cycles in WAIT_TERM before the frame is declared failed.
- REQ-002 Parameter: OPT_HOLD, default 1, meaning: 1 = honour received HOLD with HOLDA; 0 = ignore HOLD.
- REQ-003 Reset and clock: i_reset, synchronous, active-high; clock i_phy_clk.
- REQ-004 i_phy_clk  input  1  clock for all logic.
- REQ-005 i_reset  input  1  synchronous active-high reset.
- REQ-006 s_valid  input  1  FIS dword available.
- REQ-007 s_ready  output  1  FIS dword consumed this cycle.
- REQ-008 s_data  input  32  FIS dword.
- REQ-009 s_last  input  1  final dword of FIS.
- REQ-010 i_rx_prim  input  1  i_rx_data holds a primitive from the host.
- REQ-011 i_rx_data  input  32  received dword/primitive.
- REQ-012 o_tx_ctrl  output  1  o_tx_data is a primitive (K28.3/K28.5 in byte 0).
- REQ-013 o_tx_data  output  32  transmitted dword.
- REQ-014 o_busy  output  1  state is not IDLE.
- REQ-015 o_done  output  1  one-cycle pulse: frame ended with R_OK.
- REQ-016 o_err  output  1  one-cycle pulse: frame ended with R_ERR, SYNC abort, or timeout.

Function
- REQ-017 Primitive values: SYNC 0xB5B5957C, X_RDY 0x5757B57C, R_RDY 0x4A4A957C, SOF 0x3737B57C, EOF 0xD5D5B57C, WTRM 0x5858B57C, R_OK 0x3535B57C, R_ERR 0x5656B57C, HOLD 0xD5D5AA7C, HOLDA 0x9595AA7C.
- REQ-018 States: IDLE, XRDY, SOF, DATA, CRC, EOF, WAIT_TERM; o_tx_data/o_tx_ctrl registered, one cycle after the state decision.
- REQ-019 IDLE: transmit SYNC (ctrl=1); s_valid=1 -> XRDY.
- REQ-020 XRDY: transmit X_RDY until i_rx_prim && i_rx_data==R_RDY -> SOF.
- REQ-021 SOF: transmit SOF for exactly one cycle; load CRC with 0x52325032 -> DATA.
- REQ-022 DATA: s_ready = s_valid && !(OPT_HOLD && rx HOLD); accepted dword sent with ctrl=0 next cycle; CRC-32 (poly 0x04C11DB7, MSB-first, no reflection, no final XOR) updated with it.
- REQ-023 DATA, no word sent (s_valid=0): transmit HOLD; rx HOLD with OPT_HOLD=1: transmit HOLDA, s_ready=0.
- REQ-024 DATA, accepted word with s_last=1 -> CRC; CRC transmits final CRC value (ctrl=0) for one cycle -> EOF one cycle -> WAIT_TERM.
- REQ-025 WAIT_TERM: transmit WTRM; rx R_OK -> o_done, IDLE; rx R_ERR or SYNC -> o_err, IDLE; WTRM_TIMEOUT cycles elapsed -> o_err, IDLE.
- REQ-026 Abort: rx SYNC while in SOF/DATA/CRC/EOF -> transmit SYNC, o_err pulse, s_ready=1 (drain) until a dword with s_last accepted, then IDLE; if no residual dwords (s_last already taken), IDLE immediately.
- REQ-027 Received non-primitive dwords (i_rx_prim=0) ignored in all states.
- REQ-028 o_done and o_err never asserted in the same cycle; o_busy=0 only in IDLE.
- REQ-029 Timeout counter clears on entering WAIT_TERM; width clog2(WTRM_TIMEOUT+1).
- REQ-030 s_ready=0 in all states other than DATA and abort-drain.

Reset
- REQ-031 i_reset sampled at i_phy_clk: state=IDLE, o_tx_data=SYNC, o_tx_ctrl=1, s_ready=0, o_busy=0, o_done=0, o_err=0, CRC=0x52325032, counter=0.
- REQ-032 Reset mid-frame discards the frame without draining the source; no o_err pulse.

Verification
- REQ-033 Idle: s_valid=0 for 20 cycles -> o_tx_data=0xB5B5957C, o_tx_ctrl=1 every cycle.
- REQ-034 5-dword D2H FIS {0x00770027,0,0,0,0}, R_RDY after 3 cycles, R_OK after 4 WTRM -> X_RDY x>=3, SOF, 5 dwords in order, CRC matching software model, EOF, WTRM, o_done once.
- REQ-035 s_valid dropped 2 cycles mid-frame -> 2 HOLD primitives inserted, CRC unchanged vs REQ-034.
- REQ-036 Host sends HOLD 3 cycles during DATA (OPT_HOLD=1) -> 3 HOLDA, s_ready=0 for those cycles, no data lost.
- REQ-037 Host sends SYNC after 2nd dword -> SYNC transmitted next cycle, o_err pulse, remaining 3 dwords drained, IDLE.
- REQ-038 No host reply in WAIT_TERM -> o_err exactly WTRM_TIMEOUT cycles after entry, then SYNC.
